// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the boot-ROM instruction fetcher: FSM state
// encoding, address step / alignment constants and the queue entry layout.
package rom_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } fetch_state_t;

  // Byte distance between consecutive instruction words
  localparam logic [31:0] PC_INC = 32'd4;

  // Clears the two byte-offset bits of an address
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // One prefetched instruction together with the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/rom_fetch_if.sv
// Boot-ROM read bus: registered request/address from the fetcher, data and
// a ready strobe returned by the ROM exactly one cycle after each request.
interface rom_fetch_if;

  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ready;

  // Fetcher side
  modport master (
    output o_bus_request,
    output o_bus_address,
    input  i_bus_rdata,
    input  i_bus_ready
  );

  // ROM side
  modport slave (
    input  o_bus_request,
    input  o_bus_address,
    output i_bus_rdata,
    output i_bus_ready
  );

endinterface

// File: rtl/rom_fetch_queue.sv
// fetch_queue: small circular FIFO of fetched instructions. The head entry
// is readable combinationally; push and pop in the same cycle are accepted
// even when full, and flush empties the queue in one edge.
module fetch_queue
  import rom_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a full queue still takes a push
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Entry storage; cleared on reset so the head is never undefined
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; flush takes priority over any push/pop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rom_fetch.sv
// rom_fetch: sequential instruction fetcher for a fixed-latency boot ROM.
// Requests are issued against a credit that counts queued entries plus the
// one response that may still be in flight; jumps flush the queue and kill
// the in-flight response. Build option: ROM_FETCH_PREFETCH_EN enables a
// QUEUE_DEPTH-deep prefetch window; without it only one instruction is ever
// outstanding (one instruction every three cycles).
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_jump,
  input  logic [31:0]       i_jump_pc,
  rom_fetch_if.master       bus,
  output logic              o_valid,
  output logic [31:0]       o_instruction,
  output logic [31:0]       o_pc,
  input  logic              i_ready
);

`ifdef ROM_FETCH_PREFETCH_EN
  localparam int CREDIT_DEPTH = QUEUE_DEPTH;
`else
  // Storage stays QUEUE_DEPTH deep but only one entry is ever committed
  localparam int CREDIT_DEPTH = 1;
`endif

  localparam int          CNT_W      = $clog2(QUEUE_DEPTH + 1);
  localparam int          SUM_W      = CNT_W + 1;
  localparam logic [31:0] START_PC   = RESET_PC & WORD_ALIGN_MASK;

  fetch_state_t state_q;
  logic         req_q;
  logic [31:0]  addr_q;
  logic [31:0]  fetch_pc_q;
  logic         resp_live_q;
  logic [31:0]  resp_pc_q;

  fetch_entry_t     q_head;
  fetch_entry_t     push_entry;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;

  logic             pop_en;
  logic             push_en;
  logic             live_d;
  logic [SUM_W-1:0] occ_after;
  logic [SUM_W-1:0] committed;
  logic             credit;
  logic             issue_d;
  logic [31:0]      issue_pc_d;

  assign bus.o_bus_request = req_q;
  assign bus.o_bus_address = addr_q;

  assign o_valid       = !q_empty;
  assign o_instruction = o_valid ? q_head.instr : 32'h0;
  assign o_pc          = o_valid ? q_head.pc    : 32'h0;

  assign push_entry = {resp_pc_q, bus.i_bus_rdata};

  // Handshakes, issue credit and next fetch address for the coming edge
  always_comb begin
    pop_en     = o_valid && i_ready && !i_jump;
    // Responses are dropped while idle and when their request was killed
    push_en    = bus.i_bus_ready && resp_live_q && !i_jump && (state_q != S_IDLE);
    // The request on the bus now returns next edge unless a jump kills it
    live_d     = req_q && !i_jump;
    occ_after  = '0;
    if (!i_jump) begin
      occ_after = SUM_W'(q_count) + SUM_W'(push_en) - SUM_W'(pop_en);
    end
    committed  = occ_after + SUM_W'(live_d);
    // Never issue into a full queue that is not draining this edge
    credit     = (committed < SUM_W'(CREDIT_DEPTH)) && !(q_full && !pop_en);
    issue_d    = i_jump || ((state_q != S_IDLE) && credit);
    issue_pc_d = i_jump ? word_align(i_jump_pc) : fetch_pc_q;
  end

  // Fetch FSM with registered bus request, address and response tracking
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= START_PC;
      fetch_pc_q  <= START_PC;
      resp_live_q <= 1'b0;
      resp_pc_q   <= 32'h0;
    end else begin
      req_q       <= issue_d;
      resp_live_q <= live_d;
      if (issue_d) begin
        addr_q     <= issue_pc_d;
        fetch_pc_q <= issue_pc_d + PC_INC;
      end
      if (req_q) begin
        resp_pc_q <= addr_q;
      end
      case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        default: state_q <= (i_jump || credit) ? S_FETCH : S_STALL;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (i_clock),
    .rst_n_i     (i_reset_n),
    .flush_i     (i_jump),
    .push_i      (push_en),
    .push_data_i (push_entry),
    .pop_i       (pop_en),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: ROM model with data[i] = i*0x11, a scoreboard of the
// expected instruction stream refilled on every reset/jump, and timing
// checks around reset release, jumps, stalls and throughput.
module tb_rom_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef ROM_FETCH_PREFETCH_EN
  localparam int EXP_DEPTH = 4;
  localparam int EXP_RATE  = 30;
`else
  localparam int EXP_DEPTH = 1;
  localparam int EXP_RATE  = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump;
  logic [31:0] jump_pc;
  logic        rdy;
  logic        inject;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;

  logic        rom_ready_q;
  logic [31:0] rom_rdata_q;

  logic [63:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;
  int          resp_cnt = 0;
  int          pop_cnt  = 0;
  int          n;

  rom_fetch_if bus ();

  rom_fetch #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (4)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_jump        (jump),
    .i_jump_pc     (jump_pc),
    .bus           (bus),
    .o_valid       (valid),
    .o_instruction (instr),
    .o_pc          (pc),
    .i_ready       (rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr >> 2) * 32'h11;
  endfunction

  // Fixed one-cycle ROM; inject forces a spurious response strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ready_q <= 1'b0;
      rom_rdata_q <= 32'h0;
    end else begin
      rom_ready_q <= bus.o_bus_request;
      rom_rdata_q <= rom_word(bus.o_bus_address);
    end
  end
  assign bus.i_bus_ready = rom_ready_q | inject;
  assign bus.i_bus_rdata = inject ? 32'hDEAD_BEEF : rom_rdata_q;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back({a, rom_word(a)});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_valid"}, 64'(valid), 64'd0);
    check_value({tag, "_req"}, 64'(bus.o_bus_request), 64'd0);
    check_value({tag, "_addr"}, 64'(bus.o_bus_address), 64'(RESET_PC));
    check_value({tag, "_instr"}, 64'(instr), 64'd0);
    check_value({tag, "_pc"}, 64'(pc), 64'd0);
  endtask

  // Scoreboard: every accepted head entry is compared with the expected stream
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_cnt = 0;
        pop_cnt  = 0;
      end else begin
        if (bus.i_bus_ready) resp_cnt++;
        if (valid && rdy && !jump) begin
          if (exp_q.size() == 0) begin
            check_value("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            $display("pop pc=%08h instr=%08h", pc, instr);
            check_value("sb_pc", 64'(pc), 64'(e[63:32]));
            check_value("sb_instr", 64'(instr), 64'(e[31:0]));
            pop_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; jump = 1'b0; jump_pc = 32'h0; rdy = 1'b1; inject = 1'b0;
    #1;
    check_reset_outputs("por");
    tick(); tick();

    // Reset release: request on the second edge, first instruction two edges later
    new_stream(RESET_PC);
    rst_n = 1'b1;
    tick();
    check_value("e0_req", 64'(bus.o_bus_request), 64'd0);
    check_value("e0_valid", 64'(valid), 64'd0);
    tick();
    check_value("e1_req", 64'(bus.o_bus_request), 64'd1);
    check_value("e1_addr", 64'(bus.o_bus_address), 64'(RESET_PC));
    check_value("e1_valid", 64'(valid), 64'd0);
    tick();
    check_value("e2_valid", 64'(valid), 64'd0);
    tick();
    check_value("e3_valid", 64'(valid), 64'd1);
    check_value("e3_pc", 64'(pc), 64'(RESET_PC));
    repeat (8) tick();

    // Decode stall: queue fills to its effective depth, requests stop
    rdy = 1'b0;
    repeat (10) tick();
    check_value("stall_req", 64'(bus.o_bus_request), 64'd0);
    check_value("stall_valid", 64'(valid), 64'd1);
    check_value("stall_held", 64'(resp_cnt - pop_cnt), 64'(EXP_DEPTH));
    rdy = 1'b1;
    repeat (6) tick();

    // Throughput over a 30-cycle window
    n = 0;
    repeat (30) begin
      tick();
      if (valid) n++;
    end
    check_value("rate", 64'(n), 64'(EXP_RATE));

    // Misaligned jump target mid-stream
    jump = 1'b1; jump_pc = 32'h0000_0103;
    new_stream(32'h0000_0100);
    tick();
    jump = 1'b0;
    check_value("jmp_valid0", 64'(valid), 64'd0);
    check_value("jmp_req", 64'(bus.o_bus_request), 64'd1);
    check_value("jmp_addr", 64'(bus.o_bus_address), 64'h100);
    tick();
    check_value("jmp_valid1", 64'(valid), 64'd0);
    tick();
    check_value("jmp_valid2", 64'(valid), 64'd1);
    check_value("jmp_pc", 64'(pc), 64'h100);
    check_value("jmp_instr", 64'(instr), 64'h440);
    repeat (10) tick();

    // Back-to-back jumps with a full queue: only the second stream survives
    rdy = 1'b0;
    repeat (8) tick();
    check_value("b2b_full", 64'(valid), 64'd1);
    jump = 1'b1; jump_pc = 32'h0000_0020;
    new_stream(32'h0000_0020);
    tick();
    jump_pc = 32'h0000_0080;
    new_stream(32'h0000_0080);
    rdy = 1'b1;
    check_value("b2b_valid0", 64'(valid), 64'd0);
    tick();
    jump = 1'b0;
    check_value("b2b_req", 64'(bus.o_bus_request), 64'd1);
    check_value("b2b_addr", 64'(bus.o_bus_address), 64'h80);
    check_value("b2b_valid1", 64'(valid), 64'd0);
    tick();
    check_value("b2b_valid2", 64'(valid), 64'd0);
    tick();
    check_value("b2b_valid3", 64'(valid), 64'd1);
    check_value("b2b_pc", 64'(pc), 64'h80);
    check_value("b2b_instr", 64'(instr), 64'h220);
    repeat (12) tick();

    // Reset pulse mid-stream, with a spurious response right after release
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    new_stream(RESET_PC);
    tick(); tick();
    rst_n = 1'b1; inject = 1'b1;
    tick();
    inject = 1'b0;
    check_value("r0_valid", 64'(valid), 64'd0);
    check_value("r0_req", 64'(bus.o_bus_request), 64'd0);
    tick();
    check_value("r1_req", 64'(bus.o_bus_request), 64'd1);
    check_value("r1_addr", 64'(bus.o_bus_address), 64'(RESET_PC));
    tick();
    check_value("r2_valid", 64'(valid), 64'd0);
    tick();
    check_value("r3_valid", 64'(valid), 64'd1);
    check_value("r3_pc", 64'(pc), 64'(RESET_PC));
    check_value("r3_instr", 64'(instr), 64'(rom_word(RESET_PC)));
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch.md
ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-003 SHALL have port i_clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_jump  input  1  redirect fetch stream, sampled on rising edge.
REQ-006 SHALL have port i_jump_pc  input  32  redirect target.
REQ-007 SHALL have port o_bus_request  output  1  registered read request to boot ROM.
REQ-008 SHALL have port o_bus_address  output  32  registered byte address, word aligned.
REQ-009 SHALL have port i_bus_rdata  input  32  ROM read data, valid when i_bus_ready high.
REQ-010 SHALL have port i_bus_ready  input  1  ROM response strobe, one cycle after each sampled request.
REQ-011 SHALL have port o_valid  output  1  instruction available to decode.
REQ-012 SHALL have port o_instruction  output  32  head-of-queue instruction word.
REQ-013 SHALL have port o_pc  output  32  address of o_instruction.
REQ-014 SHALL have port i_ready  input  1  decode accepts head entry when o_valid and i_ready high at an edge.

Function
REQ-015 SHALL treat the ROM as fixed latency: request visible in cycle n yields i_bus_ready/i_bus_rdata in cycle n+1; no response without a request.
REQ-016 SHALL run FSM S_IDLE -> S_FETCH on first edge after reset; S_FETCH <-> S_STALL when issue credit is absent/present; any state -> S_FETCH on i_jump.
REQ-017 SHALL issue a request at an edge only if (queue occupancy after that edge + live requests still to return) < QUEUE_DEPTH; one request per cycle maximum.
REQ-018 SHALL increment fetch address by 4 per issued request, wrapping 32'hFFFFFFFC -> 32'h00000000.
REQ-019 SHALL push {address, i_bus_rdata} into the queue on every i_bus_ready edge not marked killed; push order equals issue order.
REQ-020 SHALL present queue head combinationally on o_valid/o_instruction/o_pc; pop on o_valid && i_ready; simultaneous push and pop on full or empty queue SHALL be lossless.
REQ-021 SHALL on i_jump at edge Ej: clear queue (o_valid low after Ej, pop ignored), issue request to {i_jump_pc[31:2],2'b00} after Ej, and discard the response captured at Ej+1.
REQ-022 SHALL force i_jump_pc[1:0] to zero; no misalignment fault.
REQ-023 SHALL deliver first instruction with o_valid high two edges after first request edge (reset or jump).
REQ-024 SHALL treat back-to-back jumps as independent: each kills every previously live response; only the latest target's stream enters the queue.
REQ-025 SHALL sustain one instruction per cycle with i_ready held high when prefetch is enabled.

Reset
REQ-026 SHALL on i_reset_n low asynchronously set o_bus_request=0, o_bus_address=RESET_PC, queue empty, o_valid=0, o_instruction=0, o_pc=0, kill flags clear, FSM S_IDLE.
REQ-027 SHALL discard any response arriving in the first cycle after reset release.

Configuration
REQ-028 SHALL compile prefetch with macro ROM_FETCH_PREFETCH_EN: defined -> REQ-017 credit rule over QUEUE_DEPTH entries.
REQ-029 SHALL without ROM_FETCH_PREFETCH_EN use effective depth 1: issue only when queue empty and no live request; throughput one instruction per 3 cycles; QUEUE_DEPTH ignored.

Structure
REQ-030 SHALL place FSM state enum, PC increment constant (4) and word-align mask in shared package rom_fetch_pkg.
REQ-031 SHALL implement the queue as sub-module fetch_queue (parameterised depth, push/pop/full/empty/count, async active-low reset).

Verification
REQ-032 Reset release, ROM model preloaded data[i]=i*0x11, i_ready=1 -> first o_valid two edges after first request, o_pc 0x0,0x4,0x8..., o_instruction 0x00,0x11,0x22..., one per cycle.
REQ-033 i_ready=0 for 10 cycles -> exactly QUEUE_DEPTH (4) entries held, o_bus_request low, no entry lost or duplicated on resume.
REQ-034 i_jump with i_jump_pc=0x103 mid-stream -> stale response dropped, next o_valid has o_pc=0x100, instruction data[0x40].
REQ-035 Jump on consecutive cycles to 0x20 then 0x80, queue full, i_ready=1 -> only 0x80 stream emerges.
REQ-036 i_reset_n pulsed low mid-stream -> all outputs at reset values immediately, fetch restarts at RESET_PC.
REQ-037 Build without ROM_FETCH_PREFETCH_EN -> o_valid pulses every 3 cycles, addresses 0x0,0x4,0x8.
